// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: one quotient bit per clock, Start/Done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (adds a sign fix-up cycle).
module shift_sub_divider #(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] Rem,
  output logic         Done,
  output logic         Busy,
  output logic         DivByZero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   dvd_q;
  logic [N-1:0]   dvs_q;
  logic [N-1:0]   acc_q;
  logic [N-1:0]   q_q;
  logic [N-1:0]   rem_q;
  logic           done_q;
  logic           busy_q;
  logic           dbz_q;

  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [N:0]     acc_sh;
  logic [N-1:0]   diff;
  logic           ge;
  logic [N-1:0]   acc_d;
  logic [N-1:0]   dvd_d;

`ifdef DIV_SIGNED_EN
  logic           qneg_q;
  logic           rneg_q;

  assign a_mag = A[N-1] ? -A : A;
  assign b_mag = B[N-1] ? -B : B;
`else
  assign a_mag = A;
  assign b_mag = B;
`endif

  // The shifted partial remainder is N+1 bits; if its top bit is set it
  // certainly exceeds the divisor, so only the low N bits need subtracting.
  always_comb begin
    acc_sh = {acc_q, dvd_q[N-1]};
    diff   = acc_sh[N-1:0] - dvs_q;
    ge     = acc_sh[N] | (acc_sh[N-1:0] >= dvs_q);
    acc_d  = ge ? diff : acc_sh[N-1:0];
    dvd_d  = {dvd_q[N-2:0], ge};
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            busy_q <= 1'b1;
            acc_q  <= '0;
            cnt_q  <= CW'(N - 1);
            dvd_q  <= a_mag;
            dvs_q  <= b_mag;
`ifdef DIV_SIGNED_EN
            qneg_q <= A[N-1] ^ B[N-1];
            rneg_q <= A[N-1];
`endif
            // A zero divisor skips the iteration and reports the fixed result.
            if (B == '0) begin
              q_q     <= '1;
              rem_q   <= A;
              dbz_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              dbz_q   <= 1'b0;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          dvd_q <= dvd_d;
          if (cnt_q == '0) begin
`ifdef DIV_SIGNED_EN
            state_q <= S_FIX;
`else
            q_q     <= dvd_d;
            rem_q   <= acc_d;
            state_q <= S_DONE;
`endif
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
`ifdef DIV_SIGNED_EN
        S_FIX: begin
          q_q     <= qneg_q ? -dvd_q : dvd_q;
          rem_q   <= rneg_q ? -acc_q : acc_q;
          state_q <= S_DONE;
        end
`endif
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Q         = q_q;
  assign Rem       = rem_q;
  assign Done      = done_q;
  assign Busy      = busy_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Randomized self-checking bench for shift_sub_divider against an arithmetic model.
// Honours DIV_SIGNED_EN the same way the design does.
module tb_shift_sub_divider;

  localparam int N = 8;
`ifdef DIV_SIGNED_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N + 1;
`endif

  logic         Clock   = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start   = 1'b0;
  logic [N-1:0] A       = '0;
  logic [N-1:0] B       = '0;
  logic [N-1:0] Q;
  logic [N-1:0] Rem;
  logic         Done;
  logic         Busy;
  logic         DivByZero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  shift_sub_divider #(.N(N)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .A         (A),
    .B         (B),
    .Q         (Q),
    .Rem       (Rem),
    .Done      (Done),
    .Busy      (Busy),
    .DivByZero (DivByZero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain division operators, with the zero-divisor rule applied first.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] q, output logic [N-1:0] r,
                       output logic z, output int lat);
`ifdef DIV_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == '0) begin
      q   = '1;
      r   = a;
      z   = 1'b1;
      lat = 1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
      q  = N'(sa / sb);
      r  = N'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
      z   = 1'b0;
      lat = LAT;
    end
  endtask

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit inject);
    logic [N-1:0] eq;
    logic [N-1:0] er;
    logic         ez;
    int           el;
    int           lat;
    model(a, b, eq, er, ez, el);
    @(negedge Clock);
    A = a;
    B = b;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    A = N'($urandom);
    B = N'($urandom);
    check("busy_after_accept", 32'(Busy), 1);
    lat = 0;
    while (!Done && lat < 4 * LAT) begin
      @(posedge Clock);
      #1;
      lat++;
      if (inject && lat == 3) begin
        A = 1;
        B = 1;
        Start = 1'b1;
      end else if (inject && lat == 4) begin
        Start = 1'b0;
      end
    end
    check("latency", 32'(lat), 32'(el));
    check("quotient", 32'(Q), 32'(eq));
    check("remainder", 32'(Rem), 32'(er));
    check("div_by_zero", 32'(DivByZero), 32'(ez));
    $display("op %0d / %0d -> q=%0d rem=%0d dbz=%0b lat=%0d", a, b, Q, Rem, DivByZero, lat);
    @(posedge Clock);
    #1;
    check("done_single_cycle", 32'(Done), 0);
    check("idle_after_done", 32'(Busy), 0);
  endtask

  initial begin
    #15;
    check("rst_q", 32'(Q), 0);
    check("rst_rem", 32'(Rem), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_dbz", 32'(DivByZero), 0);
    #5;
    Reset_n = 1'b1;

    do_op(8'd120, 8'd10, 1'b0);
    do_op(8'd255, 8'd16, 1'b0);
    do_op(8'd7,   8'd9,  1'b0);
    do_op(8'd250, 8'd1,  1'b0);
    do_op(8'd150, 8'd0,  1'b0);
    do_op(8'd9,   8'd3,  1'b0);
    do_op(8'd255, 8'd255, 1'b0);
    do_op(8'd255, 8'd1,  1'b0);
    do_op(8'd156, 8'd7,  1'b0);
    do_op(8'd100, 8'd249, 1'b0);
    do_op(8'd128, 8'd255, 1'b0);
    do_op(8'd120, 8'd10, 1'b1);

    begin : held_start
      logic [N-1:0] eq;
      logic [N-1:0] er;
      logic         ez;
      int           el;
      int           dones;
      int           prev_rise;
      logic         prev_done;
      model(8'd200, 8'd7, eq, er, ez, el);
      @(negedge Clock);
      A = 8'd200;
      B = 8'd7;
      Start = 1'b1;
      dones = 0;
      prev_rise = -1;
      prev_done = 1'b0;
      for (int cyc = 1; cyc <= 1 + LAT + 2 * (LAT + 1); cyc++) begin
        @(posedge Clock);
        #1;
        if (Done) begin
          check("held_pulse_width", 32'(prev_done), 0);
          check("held_quotient", 32'(Q), 32'(eq));
          check("held_remainder", 32'(Rem), 32'(er));
          if (prev_rise < 0) check("held_first_done", 32'(cyc), 32'(1 + LAT));
          else check("held_spacing", 32'(cyc - prev_rise), 32'(LAT + 1));
          $display("held op done at cycle %0d q=%0d rem=%0d", cyc, Q, Rem);
          prev_rise = cyc;
          dones++;
        end
        prev_done = Done;
      end
      Start = 1'b0;
      check("held_done_count", 32'(dones), 3);
      @(posedge Clock);
      #1;
      check("held_idle_after", 32'(Busy), 0);
    end

    begin : mid_reset
      bit seen;
      @(negedge Clock);
      A = 8'd200;
      B = 8'd7;
      Start = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      repeat (4) @(posedge Clock);
      @(negedge Clock);
      Reset_n = 1'b0;
      #1;
      check("mrst_q", 32'(Q), 0);
      check("mrst_rem", 32'(Rem), 0);
      check("mrst_done", 32'(Done), 0);
      check("mrst_busy", 32'(Busy), 0);
      check("mrst_dbz", 32'(DivByZero), 0);
      repeat (2) @(negedge Clock);
      Reset_n = 1'b1;
      seen = 1'b0;
      repeat (15) begin
        @(posedge Clock);
        #1;
        if (Done) seen = 1'b1;
      end
      check("no_done_after_reset", 32'(seen), 0);
      $display("reset mid-operation abandoned the run");
      do_op(8'd200, 8'd7, 1'b0);
    end

    for (int i = 0; i < 25; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      ra = N'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      do_op(ra, rb, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
